// File: rtl/instr_memory.sv
// ============================================================================
// Module      : instr_memory
// Description : Instruction-memory responder serving 128-bit block reads for
//               an instruction cache, with a word-wide program-load port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_memory #(
    parameter int unsigned LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_read,
    input  logic [5:0]   mem_address,
    output logic         mem_busywait,
    output logic [127:0] mem_inst,
    input  logic         prog_we,
    input  logic [7:0]   prog_addr,
    input  logic [31:0]  prog_data,
    output logic         prog_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_e         state_q;
    logic [7:0]     count_q;
    logic [5:0]     addr_q;
    logic [127:0]   inst_q;
    logic [31:0]    mem_q [0:255];
    logic [127:0]   block_rd;
    logic           prog_wr_en;

    assign block_rd = {mem_q[{addr_q, 2'd3}], mem_q[{addr_q, 2'd2}],
                       mem_q[{addr_q, 2'd1}], mem_q[{addr_q, 2'd0}]};

    // Busywait in IDLE follows mem_read directly so the cache never observes
    // a spurious low on the cycle it raises its request.
    always_comb begin
        mem_busywait = 1'b0;
        case (state_q)
            S_IDLE:  mem_busywait = mem_read;
            S_BUSY:  mem_busywait = 1'b1;
            default: mem_busywait = 1'b0;
        endcase
        if (!reset) begin
            mem_busywait = 1'b0;
        end
    end

    assign prog_busy  = reset & ((state_q != S_IDLE) | mem_read);
    assign prog_wr_en = prog_we & ~prog_busy;
    assign mem_inst   = inst_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
            addr_q  <= 6'd0;
            inst_q  <= 128'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_read) begin
                        addr_q  <= mem_address;
                        count_q <= CNT_INIT;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!mem_read) begin
                        state_q <= S_IDLE;
                    end else if (count_q == 8'd0) begin
                        inst_q  <= block_rd;
                        state_q <= S_DONE;
                    end else begin
                        count_q <= count_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clock) begin
        if (prog_wr_en) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

endmodule

`default_nettype wire
